rob_commit_buffer: RTL and testbench

- 32-entry reorder buffer; sits downstream of rename/dispatch and in parallel with the reservation stations.
- Allocates one entry per cycle in program order and hands its index to the reservation-station entry.
- Records writeback results out of order from the functional units.
- Retires one completed instruction per cycle in order to the commit/free-list stage.

---
 rtl/rob_commit_buffer.sv | 131 +++++++++++++
 tb/tb_rob_commit_buffer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_commit_buffer.sv
// 32-entry reorder buffer: allocates in program order, takes writebacks in any order,
// and retires completed entries in order from the head.
module rob_commit_buffer #(
    parameter int DEPTH  = 32,
    parameter int IDX_W  = 5,
    parameter int PREG_W = 6,
    parameter int DATA_W = 32,
    parameter int OP_W   = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alloc_valid,
    output logic              alloc_ready,
    input  logic [PREG_W-1:0] alloc_old_preg,
    input  logic [PREG_W-1:0] alloc_curr_preg,
    input  logic [OP_W-1:0]   alloc_opcode,
    output logic [IDX_W-1:0]  alloc_idx,
    input  logic              wb_valid,
    input  logic [IDX_W-1:0]  wb_idx,
    input  logic [DATA_W-1:0] wb_value,
    input  logic              commit_ready,
    output logic              commit_valid,
    output logic [IDX_W-1:0]  commit_idx,
    output logic [PREG_W-1:0] commit_old_preg,
    output logic [PREG_W-1:0] commit_curr_preg,
    output logic [OP_W-1:0]   commit_opcode,
    output logic [DATA_W-1:0] commit_value,
    input  logic              flush,
    output logic [IDX_W:0]    free_count
);

    localparam logic [IDX_W:0] DEPTH_CNT = (IDX_W + 1)'(DEPTH);

    logic [DEPTH-1:0]  in_use;
    logic [DEPTH-1:0]  is_complete;
    logic [PREG_W-1:0] old_preg_mem  [DEPTH];
    logic [PREG_W-1:0] curr_preg_mem [DEPTH];
    logic [OP_W-1:0]   opcode_mem    [DEPTH];
    logic [DATA_W-1:0] value_mem     [DEPTH];

    logic [IDX_W-1:0]  head;
    logic [IDX_W-1:0]  tail;
    logic [IDX_W:0]    count;

    logic              alloc_fire;
    logic              wb_fire;
    logic              commit_fire;

    // Readiness looks only at count, so a full buffer refuses allocation even while committing.
    assign alloc_ready  = (count != DEPTH_CNT);
    assign alloc_idx    = tail;
    assign free_count   = DEPTH_CNT - count;

    assign commit_valid     = in_use[head] & is_complete[head];
    assign commit_idx       = head;
    assign commit_old_preg  = old_preg_mem[head];
    assign commit_curr_preg = curr_preg_mem[head];
    assign commit_opcode    = opcode_mem[head];
    assign commit_value     = value_mem[head];

    always_comb begin
        // NOTE: every always_comb output is given a default first, so no path can leave it
        // unassigned and infer a latch.
        alloc_fire  = 1'b0;
        wb_fire     = 1'b0;
        commit_fire = 1'b0;
        if (!flush) begin
            alloc_fire  = alloc_valid & alloc_ready;
            // A writeback to a free slot (including the tail being allocated now) is dropped.
            wb_fire     = wb_valid & in_use[wb_idx];
            commit_fire = commit_valid & commit_ready;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples
    // pre-edge values regardless of statement order inside or across blocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_use      <= '0;
            is_complete <= '0;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
        end else if (flush) begin
            in_use      <= '0;
            is_complete <= '0;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
        end else begin
            if (alloc_fire) begin
                in_use[tail]      <= 1'b1;
                is_complete[tail] <= 1'b0;
                tail              <= tail + IDX_W'(1);
            end
            if (wb_fire) begin
                is_complete[wb_idx] <= 1'b1;
            end
            // Commit is last so a stray writeback to the retiring head cannot resurrect it.
            if (commit_fire) begin
                in_use[head]      <= 1'b0;
                is_complete[head] <= 1'b0;
                head              <= head + IDX_W'(1);
            end
            count <= count + (IDX_W + 1)'(alloc_fire) - (IDX_W + 1)'(commit_fire);
        end
    end

    // NOTE: the payload arrays are reset as well, because the commit_* outputs read the
    // head entry directly and must show zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                old_preg_mem[i]  <= '0;
                curr_preg_mem[i] <= '0;
                opcode_mem[i]    <= '0;
                value_mem[i]     <= '0;
            end
        end else begin
            if (alloc_fire) begin
                old_preg_mem[tail]  <= alloc_old_preg;
                curr_preg_mem[tail] <= alloc_curr_preg;
                opcode_mem[tail]    <= alloc_opcode;
            end
            if (wb_fire) begin
                value_mem[wb_idx] <= wb_value;
            end
        end
    end

endmodule

// File: tb/tb_rob_commit_buffer.sv
// Bench for rob_commit_buffer: directed scenarios plus random traffic, each cycle
// compared against an in-order queue model of the reorder buffer.
module tb_rob_commit_buffer;

    logic        clk;
    logic        rst_n;
    logic        alloc_valid;
    logic        alloc_ready;
    logic [5:0]  alloc_old_preg;
    logic [5:0]  alloc_curr_preg;
    logic [6:0]  alloc_opcode;
    logic [4:0]  alloc_idx;
    logic        wb_valid;
    logic [4:0]  wb_idx;
    logic [31:0] wb_value;
    logic        commit_ready;
    logic        commit_valid;
    logic [4:0]  commit_idx;
    logic [5:0]  commit_old_preg;
    logic [5:0]  commit_curr_preg;
    logic [6:0]  commit_opcode;
    logic [31:0] commit_value;
    logic        flush;
    logic [5:0]  free_count;

    rob_commit_buffer dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .alloc_valid      (alloc_valid),
        .alloc_ready      (alloc_ready),
        .alloc_old_preg   (alloc_old_preg),
        .alloc_curr_preg  (alloc_curr_preg),
        .alloc_opcode     (alloc_opcode),
        .alloc_idx        (alloc_idx),
        .wb_valid         (wb_valid),
        .wb_idx           (wb_idx),
        .wb_value         (wb_value),
        .commit_ready     (commit_ready),
        .commit_valid     (commit_valid),
        .commit_idx       (commit_idx),
        .commit_old_preg  (commit_old_preg),
        .commit_curr_preg (commit_curr_preg),
        .commit_opcode    (commit_opcode),
        .commit_value     (commit_value),
        .flush            (flush),
        .free_count       (free_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: live instructions in program order, oldest at the front.
    typedef struct {
        int          idx;
        logic [5:0]  old_p;
        logic [5:0]  curr_p;
        logic [6:0]  op;
        logic [31:0] value;
        bit          done;
    } entry_t;

    entry_t q[$];
    int     m_tail;
    int     errors;
    int     checks;

    localparam logic [6:0] OP_R = 7'b0110011;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        int n;
        n = q.size();
        check("alloc_ready", 64'(alloc_ready), 64'(n < 32));
        check("alloc_idx", 64'(alloc_idx), 64'(m_tail));
        check("free_count", 64'(free_count), 64'(32 - n));
        if (n > 0) begin
            check("commit_idx", 64'(commit_idx), 64'(q[0].idx));
            check("commit_valid", 64'(commit_valid), 64'(q[0].done));
            if (q[0].done) begin
                check("commit_old_preg", 64'(commit_old_preg), 64'(q[0].old_p));
                check("commit_curr_preg", 64'(commit_curr_preg), 64'(q[0].curr_p));
                check("commit_opcode", 64'(commit_opcode), 64'(q[0].op));
                check("commit_value", 64'(commit_value), 64'(q[0].value));
            end
        end else begin
            check("commit_idx_empty", 64'(commit_idx), 64'(m_tail));
            check("commit_valid_empty", 64'(commit_valid), 64'(0));
        end
    endtask

    // One clock cycle: check outputs at the falling edge, drive inputs, then apply the
    // same inputs to the model at the rising edge.
    task automatic step(input bit av, input logic [5:0] o_p, input logic [5:0] c_p,
                        input logic [6:0] op, input bit wv, input logic [4:0] widx,
                        input logic [31:0] wval, input bit cr, input bit fl);
        entry_t e;
        bit a_f;
        bit c_f;
        @(negedge clk);
        check_outputs();
        alloc_valid     = av;
        alloc_old_preg  = o_p;
        alloc_curr_preg = c_p;
        alloc_opcode    = op;
        wb_valid        = wv;
        wb_idx          = widx;
        wb_value        = wval;
        commit_ready    = cr;
        flush           = fl;
        a_f = av && (q.size() < 32);
        c_f = cr && (q.size() > 0) && q[0].done;
        @(posedge clk);
        if (fl) begin
            q.delete();
            m_tail = 0;
        end else begin
            if (wv) begin
                foreach (q[i]) begin
                    if (q[i].idx == int'(widx)) begin
                        q[i].value = wval;
                        q[i].done  = 1'b1;
                    end
                end
            end
            if (c_f) void'(q.pop_front());
            if (a_f) begin
                e.idx = m_tail; e.old_p = o_p; e.curr_p = c_p; e.op = op;
                e.value = '0; e.done = 1'b0;
                q.push_back(e);
                m_tail = (m_tail + 1) % 32;
            end
        end
    endtask

    task automatic idle(input bit cr);
        step(1'b0, '0, '0, '0, 1'b0, '0, '0, cr, 1'b0);
    endtask

    task automatic alloc(input logic [5:0] o_p, input logic [5:0] c_p, input logic [6:0] op,
                         input bit cr);
        step(1'b1, o_p, c_p, op, 1'b0, '0, '0, cr, 1'b0);
    endtask

    task automatic wb(input logic [4:0] widx, input logic [31:0] wval, input bit cr);
        step(1'b0, '0, '0, '0, 1'b1, widx, wval, cr, 1'b0);
    endtask

    // Asynchronous reset asserted between edges; checked before any clock edge arrives.
    task automatic apply_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        alloc_valid = 1'b0; wb_valid = 1'b0; commit_ready = 1'b0; flush = 1'b0;
        q.delete();
        m_tail = 0;
        #1;
        check("rst_alloc_ready", 64'(alloc_ready), 64'(1));
        check("rst_alloc_idx", 64'(alloc_idx), 64'(0));
        check("rst_free_count", 64'(free_count), 64'(32));
        check("rst_commit_valid", 64'(commit_valid), 64'(0));
        check("rst_commit_opcode", 64'(commit_opcode), 64'(0));
        check("rst_commit_value", 64'(commit_value), 64'(0));
        check("rst_commit_curr", 64'(commit_curr_preg), 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        bit          av, wv, cr, fl;
        logic [4:0]  widx;
        errors = 0;
        checks = 0;
        rst_n = 1'b0;
        alloc_valid = 1'b0; alloc_old_preg = '0; alloc_curr_preg = '0; alloc_opcode = '0;
        wb_valid = 1'b0; wb_idx = '0; wb_value = '0; commit_ready = 1'b0; flush = 1'b0;
        q.delete();
        m_tail = 0;

        apply_reset();
        idle(1'b1);
        idle(1'b1);

        // Out-of-order completion, in-order retirement.
        alloc(6'd1, 6'd33, OP_R, 1'b1);
        alloc(6'd2, 6'd34, OP_R, 1'b1);
        alloc(6'd3, 6'd35, OP_R, 1'b1);
        wb(5'd2, 32'hC, 1'b1);
        wb(5'd0, 32'hA, 1'b1);
        idle(1'b1);
        idle(1'b1);
        wb(5'd1, 32'hB, 1'b1);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        // Fill to full, then commit the head while allocation is still requested.
        step(1'b0, '0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 32; i++) alloc(6'(i), 6'(i + 32), 7'(i), 1'b0);
        idle(1'b0);
        wb(5'd0, 32'h1234_5678, 1'b0);
        for (int i = 0; i < 4; i++) idle(1'b0);
        step(1'b1, 6'd9, 6'd40, 7'h11, 1'b0, '0, '0, 1'b1, 1'b0);
        alloc(6'd9, 6'd41, 7'h12, 1'b0);
        idle(1'b0);

        // Writeback to an idle slot is ignored; entry 7 later reaches the head incomplete.
        step(1'b0, '0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
        wb(5'd7, 32'hDEAD, 1'b0);
        for (int i = 0; i < 8; i++) alloc(6'(i), 6'(i + 8), 7'h13, 1'b1);
        for (int i = 0; i < 7; i++) wb(5'(i), 32'(i + 100), 1'b1);
        for (int i = 0; i < 3; i++) idle(1'b1);
        wb(5'd7, 32'hBEEF, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Flush beats a same-cycle alloc and writeback.
        for (int i = 0; i < 10; i++) alloc(6'(i), 6'(i + 20), 7'h21, 1'b0);
        wb(5'd0, 32'h55, 1'b0);
        step(1'b1, 6'd1, 6'd2, 7'h22, 1'b1, 5'd1, 32'h66, 1'b1, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Random traffic, with one asynchronous reset in the middle.
        for (int cyc = 0; cyc < 2000; cyc++) begin
            av = ($urandom_range(0, 99) < 60);
            wv = ($urandom_range(0, 99) < 55);
            cr = ($urandom_range(0, 99) < 70);
            fl = ($urandom_range(0, 299) == 0);
            if (q.size() > 0 && $urandom_range(0, 99) < 80)
                widx = 5'(q[$urandom_range(0, q.size() - 1)].idx);
            else
                widx = 5'($urandom_range(0, 31));
            step(av, 6'($urandom), 6'($urandom), 7'($urandom), wv, widx, $urandom, cr, fl);
            if (cyc == 1000) apply_reset();
        end
        idle(1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
